uart_cfg_ctrl: RTL
==================

// Module: uart_cfg_ctrl
// PURPOSE
//  Configuration sequencer between the UART receiver (AXI-Stream byte out) and the ODIN core.
//  Decodes each received byte and assembles nibbles into 8-bit gate/loop/AER registers.
//  Fires a 4-phase AER request/ack handshake toward the core for each committed AER event.
//  Sits inside fpga_core, directly after uart_rx.
// PARAMETERS
//  ACK_TIMEOUT  1023  cycles to wait for each aer_ack edge before aborting (>=1)
//  ERR_W        8     width of the saturating error counter
// PORTS
//  clk            in   1      single clock
//  rst            in   1      synchronous, active-high reset
//  s_axis_tdata   in   8      byte from uart_rx
//  s_axis_tvalid  in   1      byte valid
//  s_axis_tready  out  1      byte accepted when tvalid&tready
//  gate_reg       out  8      committed gate configuration
//  loop_reg       out  8      committed loop configuration
//  aer_addr       out  8      AER event address, stable while aer_req=1
//  aer_req        out  1      AER request to core
//  aer_ack        in   1      AER acknowledge from core (already synchronised)
//  err_cnt        out  ERR_W  count of bad bytes and timeouts, saturating
// BEHAVIOUR
//  Byte format: [7:4] nibble, [3:2] target (0 gate, 1 loop, 2 aer, 3 reserved), [1:0] op.
//  op 00 NOP; 01 load nibble into shadow[target][3:0]; 10 load shadow[target][7:4] and commit;
//    11 invalid.
//  Commit: target register <= {nibble, shadow[3:0]} one cycle after acceptance (cycle N -> N+1).
//  Commit to aer: aer_addr updated at N+1; aer_req rises at N+1; FSM leaves IDLE.
//  Target 3 or op 11: byte consumed with no register change; err_cnt+1 at N+1.
//  FSM: IDLE (tready=1) -> REQ (tready=0, aer_req=1, wait aer_ack=1)
//    -> REL (aer_req=0, wait aer_ack=0) -> IDLE.
//  tready=0 in all non-IDLE states; gate/loop bytes are accepted only in IDLE.
//  Timeout: a counter runs in REQ/REL and restarts on each state entry.
//    Reaching ACK_TIMEOUT: err_cnt+1, aer_req=0, go to IDLE.
//  If aer_ack is already 1 on entry to REQ, advance next cycle (no combinational path to aer_req).
//  err_cnt saturates at all-ones. Timeout and bad byte never coincide, since tready=0 outside IDLE.
//  Shadow low nibble persists after commit; repeated op 10 recommits with the old low nibble.
//  Reset values: all registers, shadows and err_cnt = 0; aer_req=0; FSM=IDLE; s_axis_tready=0.
//    s_axis_tready goes to 1 on the first cycle after rst deasserts.
//  rst mid-handshake: aer_req drops on the next clock edge; the in-flight event is discarded.
// CONFIGURATION
//  Macro CFG_READBACK_EN:
//  Defined: adds outputs m_axis_tdata[7:0], m_axis_tvalid and input m_axis_tready.
//    Each commit echoes {committed value} via state ECHO, entered after the commit.
//    AER commits enter ECHO after REL.
//    tvalid is held until tready; the next byte is not accepted until the handshake completes.
//    Reset tvalid=0.
//  Undefined: ports absent; no ECHO state; commit latency unchanged.
// STRUCTURE
//  Package odin_cfg_pkg:
//    target constants TGT_GATE/TGT_LOOP/TGT_AER/TGT_RSVD
//    op_e enum (OP_NOP, OP_LO, OP_HI_COMMIT, OP_BAD)
//    cfg_state_e enum (IDLE, REQ, REL, ECHO)
//    cfg_byte_t packed struct.
//  One sub-module, aer_hs_fsm: REQ/REL states plus the timeout counter.
//    Interface: start, addr in; aer_req/aer_ack; done, timeout out.
// TESTING
//  1. Reset, send 0x21 (gate lo=2), then 0x52 (gate hi=5) -> gate_reg=0x52 one cycle after the 2nd accept.
//  2. Send 0x35 then 0xA6 (loop lo=3, hi=A) -> loop_reg=0xA3; gate_reg unchanged.
//  3. Send 0x79, then 0x4A (aer lo=7, hi=4) -> aer_addr=0x47, aer_req=1.
//     Ack after 5 cycles, drop after 3 -> aer_req=0, tready=1.
//  4. AER commit with aer_ack tied 0, ACK_TIMEOUT=16 -> aer_req drops after 16 cycles in REQ; err_cnt=1.
//  5. Send 0x0C (target 3) and 0x03 (op 11) -> err_cnt=+2, no register change.
//     With ERR_W=2, 5 errors -> err_cnt=3.
//  6. rst pulse while aer_req=1 -> next cycle: aer_req=0, all regs 0.
//     With CFG_READBACK_EN and tready=0 -> tvalid held, s_axis_tready=0 until tready=1.

Source files
------------

// File: rtl/odin_cfg_pkg.sv
// Shared types for the UART configuration sequencer: byte layout, opcodes, states.
// Used by uart_cfg_ctrl (optional CFG_READBACK_EN build) and aer_hs_fsm.
package odin_cfg_pkg;

  localparam logic [1:0] TGT_GATE = 2'd0;
  localparam logic [1:0] TGT_LOOP = 2'd1;
  localparam logic [1:0] TGT_AER  = 2'd2;
  localparam logic [1:0] TGT_RSVD = 2'd3;

  typedef enum logic [1:0] {
    OP_NOP       = 2'b00,
    OP_LO        = 2'b01,
    OP_HI_COMMIT = 2'b10,
    OP_BAD       = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    ECHO = 2'd3
  } cfg_state_e;

  typedef struct packed {
    logic [3:0] nibble;
    logic [1:0] target;
    op_e        op;
  } cfg_byte_t;

  function automatic logic is_bad_byte(input cfg_byte_t b);
    return (b.target == TGT_RSVD) || (b.op == OP_BAD);
  endfunction

endpackage

// File: rtl/aer_hs_fsm.sv
// Four-phase AER request/acknowledge handshake with a per-phase timeout.
// Address is latched on start and held stable for the whole handshake.
module aer_hs_fsm
  import odin_cfg_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  output logic [7:0] aer_addr,
  output logic       aer_req,
  input  logic       aer_ack,
  output logic       done,
  output logic       timeout
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  cfg_state_e       st_r;
  cfg_state_e       st_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       addr_r;
  logic             expired_s;

  assign expired_s = (cnt_r == CNT_LAST);
  assign aer_req   = (st_r == REQ);
  assign aer_addr  = addr_r;

  // State, per-phase wait counter (cleared on every state change) and latched address
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r   <= IDLE;
      cnt_r  <= {CNT_W{1'b0}};
      addr_r <= 8'h00;
    end else begin
      st_r <= st_nx_s;
      if (st_nx_s != st_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (st_r != IDLE) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (start && (st_r == IDLE)) begin
        addr_r <= addr;
      end
    end
  end

  // Next state; an ack seen in the final REQ cycle wins over the timeout
  always_comb begin
    st_nx_s = st_r;
    done    = 1'b0;
    timeout = 1'b0;
    case (st_r)
      IDLE: begin
        if (start) st_nx_s = REQ;
        else       st_nx_s = IDLE;
      end
      REQ: begin
        if (aer_ack) begin
          st_nx_s = REL;
        end else if (expired_s) begin
          timeout = 1'b1;
          st_nx_s = IDLE;
        end else begin
          st_nx_s = REQ;
        end
      end
      REL: begin
        if (!aer_ack) begin
          done    = 1'b1;
          st_nx_s = IDLE;
        end else if (expired_s) begin
          timeout = 1'b1;
          st_nx_s = IDLE;
        end else begin
          st_nx_s = REL;
        end
      end
      default: st_nx_s = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cfg_ctrl.sv
// Decodes UART bytes into gate/loop/AER configuration and drives the AER handshake.
// Optional macro CFG_READBACK_EN adds an AXI-Stream echo of every committed value.
module uart_cfg_ctrl
  import odin_cfg_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [7:0]       gate_reg,
  output logic [7:0]       loop_reg,
  output logic [7:0]       aer_addr,
  output logic             aer_req,
  input  logic             aer_ack,
`ifdef CFG_READBACK_EN
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
`endif
  output logic [ERR_W-1:0] err_cnt
);

  cfg_byte_t        byte_s;
  cfg_state_e       st_r;
  cfg_state_e       st_nx_s;
  logic             tready_r;
  logic [7:0]       gate_r;
  logic [7:0]       loop_r;
  logic [3:0]       lo_gate_r;
  logic [3:0]       lo_loop_r;
  logic [3:0]       lo_aer_r;
  logic [ERR_W-1:0] err_r;
  logic             accept_s;
  logic             bad_s;
  logic             commit_s;
  logic             hs_start_s;
  logic             hs_done_s;
  logic             hs_timeout_s;
  logic [3:0]       shadow_lo_s;
  logic [7:0]       commit_val_s;

  assign byte_s       = cfg_byte_t'(s_axis_tdata);
  assign accept_s     = s_axis_tvalid && tready_r;
  assign bad_s        = accept_s && is_bad_byte(byte_s);
  assign commit_s     = accept_s && !bad_s && (byte_s.op == OP_HI_COMMIT);
  assign hs_start_s   = commit_s && (byte_s.target == TGT_AER);
  assign commit_val_s = {byte_s.nibble, shadow_lo_s};

  assign s_axis_tready = tready_r;
  assign gate_reg      = gate_r;
  assign loop_reg      = loop_r;
  assign err_cnt       = err_r;

  // Low-nibble shadow of the addressed target
  always_comb begin
    shadow_lo_s = 4'h0;
    case (byte_s.target)
      TGT_GATE: shadow_lo_s = lo_gate_r;
      TGT_LOOP: shadow_lo_s = lo_loop_r;
      TGT_AER:  shadow_lo_s = lo_aer_r;
      default:  shadow_lo_s = 4'h0;
    endcase
  end

  aer_hs_fsm #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_hs (
    .clk     (clk),
    .rst     (rst),
    .start   (hs_start_s),
    .addr    (commit_val_s),
    .aer_addr(aer_addr),
    .aer_req (aer_req),
    .aer_ack (aer_ack),
    .done    (hs_done_s),
    .timeout (hs_timeout_s)
  );

  // Sequencer next state; REQ covers the whole handshake owned by u_hs
  always_comb begin
    st_nx_s = st_r;
    case (st_r)
      IDLE: begin
        if (hs_start_s) st_nx_s = REQ;
`ifdef CFG_READBACK_EN
        else if (commit_s) st_nx_s = ECHO;
`endif
        else st_nx_s = IDLE;
      end
      REQ: begin
        if (hs_timeout_s) st_nx_s = IDLE;
`ifdef CFG_READBACK_EN
        else if (hs_done_s) st_nx_s = ECHO;
`else
        else if (hs_done_s) st_nx_s = IDLE;
`endif
        else st_nx_s = REQ;
      end
`ifdef CFG_READBACK_EN
      ECHO: begin
        if (m_axis_tready) st_nx_s = IDLE;
        else               st_nx_s = ECHO;
      end
`endif
      default: st_nx_s = IDLE;
    endcase
  end

  // Sequencer state, registered ready, shadows, committed registers, error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r      <= IDLE;
      tready_r  <= 1'b0;
      gate_r    <= 8'h00;
      loop_r    <= 8'h00;
      lo_gate_r <= 4'h0;
      lo_loop_r <= 4'h0;
      lo_aer_r  <= 4'h0;
      err_r     <= {ERR_W{1'b0}};
    end else begin
      st_r     <= st_nx_s;
      tready_r <= (st_nx_s == IDLE);
      if (accept_s && !bad_s && (byte_s.op == OP_LO)) begin
        case (byte_s.target)
          TGT_GATE: lo_gate_r <= byte_s.nibble;
          TGT_LOOP: lo_loop_r <= byte_s.nibble;
          TGT_AER:  lo_aer_r  <= byte_s.nibble;
          default:  ;
        endcase
      end
      if (commit_s) begin
        case (byte_s.target)
          TGT_GATE: gate_r <= commit_val_s;
          TGT_LOOP: loop_r <= commit_val_s;
          default:  ;
        endcase
      end
      if ((bad_s || hs_timeout_s) && (err_r != {ERR_W{1'b1}})) begin
        err_r <= err_r + ERR_W'(1);
      end
    end
  end

`ifdef CFG_READBACK_EN
  logic [7:0] m_tdata_r;
  logic       m_tvalid_r;

  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tvalid = m_tvalid_r;

  // Echo register: gate/loop value at commit, AER address once the handshake completes
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata_r  <= 8'h00;
      m_tvalid_r <= 1'b0;
    end else begin
      m_tvalid_r <= (st_nx_s == ECHO);
      if (commit_s && !hs_start_s) begin
        m_tdata_r <= commit_val_s;
      end else if (hs_done_s) begin
        m_tdata_r <= aer_addr;
      end
    end
  end
`endif

endmodule
